// File: rtl/arbiter_rr_8.sv
// rtl/arbiter_rr_8.sv - 8-way round-robin arbiter with optional grant lock and hold timeout
//
// Parameters:
//   LOCK    - 1: a grant is held while its request stays high; 0: re-arbitrate every cycle
//   MAXHOLD - maximum consecutive cycles a locked grant is held while others wait (2..255)
// Ports:
//   CLK   - clock, rising edge
//   RST_N - asynchronous active-low reset
//   EN    - arbitration enable
//   REQ   - request vector, bit i = requester i
//   GNT   - registered grant, one-hot or zero
//   VLD   - registered, equals |GNT
module arbiter_rr_8 #(
    parameter int unsigned LOCK    = 1,
    parameter int unsigned MAXHOLD = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       EN,
    input  logic [7:0] REQ,
    output logic [7:0] GNT,
    output logic       VLD
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HMAX = 8'(MAXHOLD - 1);

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] win_q, win_d;
    logic [7:0] hcnt_q, hcnt_d;
    logic [7:0] gnt_q, gnt_d;
    logic       vld_q;

    // Returns {found, index} of the first set bit at or above ptr, wrapping 7->0.
    // Iterating from the far end down lets the bit closest to ptr overwrite the rest.
    function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
        logic [3:0] r;
        logic [2:0] idx;
        r = 4'b0;
        for (int k = 7; k >= 0; k--) begin
            idx = ptr + 3'(k);
            if (req[idx]) begin
                r = {1'b1, idx};
            end
        end
        return r;
    endfunction

    logic [7:0] win_oh;
    logic [7:0] others;
    logic [3:0] pick_all;
    logic [3:0] pick_oth;
    logic       load;
    logic [2:0] sel_idx;

    assign win_oh   = 8'b1 << win_q;
    assign others   = REQ & ~win_oh;
    assign pick_all = rr_pick(REQ, ptr_q);
    assign pick_oth = rr_pick(others, ptr_q);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        hcnt_d  = hcnt_q;
        gnt_d   = gnt_q;
        load    = 1'b0;
        sel_idx = pick_all[2:0];

        case (state_q)
            IDLE: begin
                gnt_d = 8'h00;
                if (EN && pick_all[3]) begin
                    load = 1'b1;
                end
            end
            GRANT: begin
                if (!EN) begin
                    gnt_d   = 8'h00;
                    state_d = IDLE;
                end else if ((LOCK == 0) || !REQ[win_q]) begin
                    // Release (or unlocked rotation): new winner at this same edge, no bubble
                    if (pick_all[3]) begin
                        load = 1'b1;
                    end else begin
                        gnt_d   = 8'h00;
                        state_d = IDLE;
                    end
                end else if ((hcnt_q == HMAX) && pick_oth[3]) begin
                    // Timeout: current winner masked off so somebody else gets a turn
                    load    = 1'b1;
                    sel_idx = pick_oth[2:0];
                end else if (hcnt_q != HMAX) begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end
            default: begin
                gnt_d   = 8'h00;
                state_d = IDLE;
            end
        endcase

        if (load) begin
            gnt_d   = 8'b1 << sel_idx;
            win_d   = sel_idx;
            ptr_d   = sel_idx + 3'd1;
            hcnt_d  = 8'h00;
            state_d = GRANT;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            win_q   <= 3'd0;
            hcnt_q  <= 8'h00;
            gnt_q   <= 8'h00;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            hcnt_q  <= hcnt_d;
            gnt_q   <= gnt_d;
            vld_q   <= |gnt_d;
        end
    end

    assign GNT = gnt_q;
    assign VLD = vld_q;

endmodule

// File: tb/tb_arbiter_rr_8.sv
// tb/tb_arbiter_rr_8.sv - self-checking bench for arbiter_rr_8
module tb_arbiter_rr_8;

    logic             CLK;
    logic             RST_N;
    logic             EN;
    logic [7:0]       REQ;
    logic [2:0][7:0]  gnt_w;
    logic [2:0]       vld_w;

    int n_checks = 0;
    int n_fail   = 0;
    string phase = "reset";

    // Instance 0: defaults (LOCK=1, MAXHOLD=16); 1: LOCK=0; 2: LOCK=1, MAXHOLD=4
    arbiter_rr_8 u_def (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .REQ(REQ), .GNT(gnt_w[0]), .VLD(vld_w[0])
    );
    arbiter_rr_8 #(.LOCK(0), .MAXHOLD(16)) u_rr (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .REQ(REQ), .GNT(gnt_w[1]), .VLD(vld_w[1])
    );
    arbiter_rr_8 #(.LOCK(1), .MAXHOLD(4)) u_to (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .REQ(REQ), .GNT(gnt_w[2]), .VLD(vld_w[2])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int owner;
        int ptr;
        int held;
    } mdl_t;

    mdl_t m [3];
    int   lock_p [3] = '{1, 0, 1};
    int   maxh_p [3] = '{16, 16, 4};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int ptr, input logic [7:0] req, input int excl);
        int i;
        for (int k = 0; k < 8; k++) begin
            i = (ptr + k) % 8;
            if (req[i] && i != excl) return i;
        end
        return -1;
    endfunction

    function automatic mdl_t step(input mdl_t s, input int lock, input int maxh,
                                  input logic en, input logic [7:0] req);
        mdl_t n;
        int   w;
        n = s;
        if (!en) begin
            n.owner = -1;
            return n;
        end
        if (s.owner >= 0 && lock != 0 && req[s.owner]) begin
            w = (s.held == maxh - 1) ? pick(s.ptr, req, s.owner) : -1;
            if (w < 0) begin
                if (n.held < maxh - 1) n.held++;
                return n;
            end
        end else begin
            w = pick(s.ptr, req, -1);
        end
        n.owner = w;
        if (w >= 0) begin
            n.ptr  = (w + 1) % 8;
            n.held = 0;
        end
        return n;
    endfunction

    function automatic logic [7:0] exp_gnt(input mdl_t s);
        return (s.owner < 0) ? 8'h00 : (8'b1 << s.owner);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) m[k] = '{owner: -1, ptr: 0, held: 0};
    endtask

    task automatic cycle();
        @(posedge CLK);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (!RST_N) m[k] = '{owner: -1, ptr: 0, held: 0};
            else        m[k] = step(m[k], lock_p[k], maxh_p[k], EN, REQ);
            chk($sformatf("%s gnt%0d", phase, k), gnt_w[k], exp_gnt(m[k]));
            chk($sformatf("%s vld%0d", phase, k), {7'b0, vld_w[k]},
                {7'b0, (m[k].owner >= 0)});
        end
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        #1;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    always @(negedge CLK) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("onehot%0d", k), {7'b0, $onehot0(gnt_w[k])}, 8'h01);
            chk($sformatf("vld_or%0d", k), {7'b0, vld_w[k]}, {7'b0, |gnt_w[k]});
        end
    end

    initial begin
        RST_N = 1'b0;
        EN    = 1'b0;
        REQ   = 8'h00;
        model_reset();
        #3;
        for (int k = 0; k < 3; k++) begin
            chk("reset gnt", gnt_w[k], 8'h00);
            chk("reset vld", {7'b0, vld_w[k]}, 8'h00);
        end

        // Fairness with LOCK=0
        phase = "fair";
        EN  = 1'b1;
        REQ = 8'hFF;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cycle();
            chk("fair seq", gnt_w[1], 8'b1 << (i % 8));
        end

        // Lock then release with no bubble
        phase = "lock";
        do_reset();
        REQ = 8'h24;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("lock hold", gnt_w[0], 8'h04);
        end
        REQ = 8'h20;
        cycle();
        chk("release gnt", gnt_w[0], 8'h20);
        chk("release vld", {7'b0, vld_w[0]}, 8'h01);

        // Timeout with MAXHOLD=4
        phase = "timeout";
        do_reset();
        REQ = 8'h03;
        for (int i = 0; i < 13; i++) begin
            cycle();
            chk("timeout seq", gnt_w[2], ((i / 4) % 2 == 1) ? 8'h02 : 8'h01);
        end

        // Pointer wrap 7 -> 0
        phase = "wrap";
        do_reset();
        REQ = 8'h40;
        cycle();
        chk("wrap pre", gnt_w[0], 8'h40);
        REQ = 8'h81;
        cycle();
        chk("wrap 80", gnt_w[0], 8'h80);
        chk("wrap 80 rr", gnt_w[1], 8'h80);
        REQ = 8'h01;
        cycle();
        chk("wrap 01", gnt_w[0], 8'h01);

        // EN dropped mid-grant keeps the pointer
        phase = "enable";
        do_reset();
        REQ = 8'h08;
        cycle();
        chk("en pre", gnt_w[0], 8'h08);
        cycle();
        EN = 1'b0;
        cycle();
        chk("en off", gnt_w[0], 8'h00);
        chk("en off vld", {7'b0, vld_w[0]}, 8'h00);
        EN  = 1'b1;
        REQ = 8'hFF;
        cycle();
        chk("en ptr kept", gnt_w[0], 8'h10);

        // Asynchronous reset mid-grant
        phase = "async";
        cycle();
        #2;
        RST_N = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            chk("async gnt", gnt_w[k], 8'h00);
            chk("async vld", {7'b0, vld_w[k]}, 8'h00);
        end
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #1;
        RST_N = 1'b1;
        #1;
        chk("post release", gnt_w[0], 8'h00);
        cycle();
        chk("first grant", gnt_w[0], 8'h01);

        // Randomized traffic against the reference model
        phase = "random";
        for (int i = 0; i < 400; i++) begin
            EN = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 11) == 0) begin
                case ($urandom_range(0, 3))
                    0: REQ = 8'($urandom);
                    1: REQ = 8'b1 << $urandom_range(0, 7);
                    2: REQ = (8'b1 << $urandom_range(0, 7)) | (8'b1 << $urandom_range(0, 7));
                    default: REQ = 8'h00;
                endcase
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
